// File: rtl/icon_pkg.sv
// Shared definitions for the 40x40 icon ROM and its clients.
// Contents: icon geometry, ROM address/pixel widths, the value returned for
// out-of-range reads, and a helper that maps (x, y) to a ROM word address.
package icon_pkg;

   localparam int ICON_W      = 40;
   localparam int ICON_H      = 40;
   localparam int ICON_DEPTH  = ICON_W * ICON_H;
   localparam int ICON_ADDR_W = 11;
   localparam int PIX_W       = 8;

   localparam logic [PIX_W-1:0] TRANSPARENT_PIX = 8'h00;

   // Row-major pixel address inside the icon.
   function automatic logic [ICON_ADDR_W-1:0] icon_addr(input int x, input int y);
      return ICON_ADDR_W'(y * ICON_W + x);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   req  [N]   : request vector
//   advance    : a grant was taken this cycle; move the pointer past the winner
//   gnt  [N]   : combinational one-hot grant, forced to 0 while rst_n is low
// Scanning starts at ptr and wraps, so a busy requester waits at most N-1
// cycles.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] win;
   logic [PTR_W-1:0] sel;
   logic             found;

   always_comb begin
      gnt   = '0;
      win   = '0;
      sel   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         sel = PTR_W'((int'(ptr) + k) % N);
         if (!found && req[sel]) begin
            gnt[sel] = 1'b1;
            win      = sel;
            found    = 1'b1;
         end
      end
      if (!rst_n) begin
         gnt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (win == PTR_W'(N - 1)) ? '0 : win + 1'b1;
      end
   end

endmodule

// File: rtl/icon_rom_arbiter.sv
// Shares one combinational icon ROM between N_REQ pixel requesters.
// One access is accepted per cycle (round-robin); the ROM address is
// registered, and the read data is registered one cycle later and returned
// with a one-hot rvalid naming the requester.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   req        : per-requester request, held with its address until gnt
//   req_addr   : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt        : combinational one-hot accept
//   rvalid     : one-hot single-cycle response marker
//   rdata      : response data, meaningful while |rvalid
//   rom_addr   : registered ROM address
//   rom_data   : combinational ROM output for rom_addr
// Latency: gnt in t, rom_addr in t+1, rvalid/rdata in t+2.
module icon_rom_arbiter
   import icon_pkg::*;
#(
   parameter int                N_REQ    = 4,
   parameter int                ADDR_W   = ICON_ADDR_W,
   parameter int                DATA_W   = PIX_W,
   parameter int                DEPTH    = ICON_DEPTH,
   parameter logic [DATA_W-1:0] OOB_DATA = TRANSPARENT_PIX
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]       rdata,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DATA_W-1:0]       rom_data
);

   // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

   logic              accept;
   logic [ADDR_W-1:0] win_addr;
   logic              win_oob;

   logic [N_REQ-1:0]  sel1;
   logic              oob1;
   logic              v1;

   rr_arbiter #(
      .N (N_REQ)
   ) u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .advance (accept),
      .gnt     (gnt)
   );

   // gnt only ever lands on a requesting bit, so any grant is a transfer.
   assign accept = |gnt;

   // gnt is one-hot, so OR-ing the gated slices selects the winner's address.
   always_comb begin
      win_addr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            win_addr = win_addr | req_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   assign win_oob = ({1'b0, win_addr} >= DEPTH_LIM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr <= '0;
         sel1     <= '0;
         oob1     <= 1'b0;
         v1       <= 1'b0;
      end else begin
         v1 <= accept;
         if (accept) begin
            rom_addr <= win_addr;
            sel1     <= gnt;
            oob1     <= win_oob;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid <= '0;
         rdata  <= '0;
      end else begin
         rvalid <= v1 ? sel1 : '0;
         if (v1) begin
            rdata <= oob1 ? OOB_DATA : rom_data;
         end
      end
   end

endmodule

// File: tb/tb_icon_rom_arbiter.sv
module tb_icon_rom_arbiter;

   localparam int N  = 4;
   localparam int AW = 11;
   localparam int DW = 8;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rvalid;
   logic [DW-1:0]   rdata;
   logic [AW-1:0]   rom_addr;
   logic [DW-1:0]   rom_data;

   icon_rom_arbiter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_addr (req_addr),
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .rom_addr (rom_addr),
      .rom_data (rom_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM model: real contents below 1600, recognisable non-zero junk above,
   // so an OOB read that leaks ROM data is visible.
   logic [DW-1:0] mem [0:2047];
   always_comb begin
      if (rom_addr < 11'd1600) rom_data = mem[rom_addr];
      else                     rom_data = 8'h80 | {1'b0, rom_addr[6:0]};
   end

   typedef struct {
      int            due;
      int            who;
      logic [DW-1:0] data;
   } resp_t;

   resp_t         exp_q[$];
   logic [DW-1:0] rv_log[$];

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   int            exp_ptr  = 0;
   int            last_win = -1;
   logic [AW-1:0] exp_rom_addr = '0;
   logic [DW-1:0] exp_rdata    = '0;

   logic [N-1:0]  obs_gnt;
   logic [N-1:0]  obs_rvalid;
   logic [DW-1:0] obs_rdata;
   logic [AW-1:0] obs_rom_addr;

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      req_addr[i*AW +: AW] = a;
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_ptr      = 0;
      exp_rom_addr = '0;
      exp_rdata    = '0;
   endtask

   // One clock cycle of scoreboarding. Inputs for the cycle are already
   // driven; outputs are sampled on the falling edge. Expected behaviour:
   // first requester at or after the rotating pointer wins, and its word
   // comes back two edges later (OOB addresses give 0).
   task automatic run_cycle();
      int            w;
      int            idx;
      logic [N-1:0]  eg;
      logic [N-1:0]  erv;
      logic [AW-1:0] wa;
      @(negedge clk);
      w = -1;
      for (int k = 0; k < N; k++) begin
         idx = (exp_ptr + k) % N;
         if (w < 0 && req[idx]) w = idx;
      end
      eg = (w >= 0) ? N'(1 << w) : '0;
      obs_gnt      = gnt;
      obs_rvalid   = rvalid;
      obs_rdata    = rdata;
      obs_rom_addr = rom_addr;
      n_checks++;
      if (gnt !== eg) begin
         n_fail++;
         $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg);
      end
      n_checks++;
      if (rom_addr !== exp_rom_addr) begin
         n_fail++;
         $display("FAIL rom_addr cyc=%0d got=%0d exp=%0d", cyc, rom_addr, exp_rom_addr);
      end
      erv = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         erv       = N'(1 << exp_q[0].who);
         exp_rdata = exp_q[0].data;
         void'(exp_q.pop_front());
      end
      n_checks++;
      if (rvalid !== erv) begin
         n_fail++;
         $display("FAIL rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, erv);
      end
      n_checks++;
      if (rdata !== exp_rdata) begin
         n_fail++;
         $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, rdata, exp_rdata);
      end
      if (rvalid != '0) rv_log.push_back(rdata);
      @(posedge clk);
      if (w >= 0) begin
         wa = req_addr[w*AW +: AW];
         exp_q.push_back('{cyc + 2, w, (wa >= 11'd1600) ? 8'h00 : mem[wa]});
         exp_ptr      = (w + 1) % N;
         exp_rom_addr = wa;
      end
      last_win = w;
      cyc++;
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req   = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic drain();
      req = '0;
      repeat (3) run_cycle();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 4'b1111;
      for (int i = 0; i < N; i++) set_addr(i, AW'(10 + i));
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
         n_checks++;
         if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0000", rvalid); end
         n_checks++;
         if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
         n_checks++;
         if (rom_addr !== 11'd0) begin n_fail++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
      end
      @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
      run_cycle();
      n_checks++;
      if (obs_gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt got=%b exp=0001", obs_gnt); end
      drain();
   endtask

   task automatic test_single();
      req = 4'b0100;
      set_addr(2, 11'd5);
      run_cycle();
      n_checks++;
      if (obs_gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got=%b exp=0100", obs_gnt); end
      req = '0;
      run_cycle();
      n_checks++;
      if (obs_rom_addr !== 11'd5) begin n_fail++; $display("FAIL single_rom_addr got=%0d exp=5", obs_rom_addr); end
      run_cycle();
      n_checks++;
      if (obs_rvalid !== 4'b0100) begin n_fail++; $display("FAIL single_rvalid got=%b exp=0100", obs_rvalid); end
      n_checks++;
      if (obs_rdata !== 8'hA5) begin n_fail++; $display("FAIL single_rdata got=%h exp=a5", obs_rdata); end
      drain();
   endtask

   task automatic test_rotation();
      logic [N-1:0] eg;
      apply_reset();
      rv_log.delete();
      req = 4'b1111;
      for (int i = 0; i < N; i++) set_addr(i, AW'(100 + 37 * i));
      for (int k = 0; k < 8; k++) begin
         run_cycle();
         eg = N'(1 << (k % N));
         n_checks++;
         if (obs_gnt !== eg) begin n_fail++; $display("FAIL rotation_gnt k=%0d got=%b exp=%b", k, obs_gnt, eg); end
         if (last_win >= 0) set_addr(last_win, AW'($urandom_range(0, 1599)));
      end
      drain();
      n_checks++;
      if (rv_log.size() != 8) begin n_fail++; $display("FAIL rotation_resp_count got=%0d exp=8", rv_log.size()); end
   endtask

   task automatic test_pointer();
      apply_reset();
      set_addr(0, 11'd20);
      set_addr(3, 11'd30);
      req = 4'b0001;
      run_cycle();
      n_checks++;
      if (obs_gnt !== 4'b0001) begin n_fail++; $display("FAIL ptr_first got=%b exp=0001", obs_gnt); end
      req = 4'b1001;
      run_cycle();
      n_checks++;
      if (obs_gnt !== 4'b1000) begin n_fail++; $display("FAIL ptr_second got=%b exp=1000", obs_gnt); end
      run_cycle();
      n_checks++;
      if (obs_gnt !== 4'b0001) begin n_fail++; $display("FAIL ptr_third got=%b exp=0001", obs_gnt); end
      drain();
   endtask

   task automatic test_boundary();
      rv_log.delete();
      req = 4'b0010;
      set_addr(1, 11'd1599);
      run_cycle();
      set_addr(1, 11'd1600);
      run_cycle();
      set_addr(1, 11'd2047);
      run_cycle();
      drain();
      n_checks++;
      if (rv_log.size() != 3) begin
         n_fail++;
         $display("FAIL boundary_count got=%0d exp=3", rv_log.size());
      end else begin
         n_checks++;
         if (rv_log[0] !== mem[1599]) begin n_fail++; $display("FAIL boundary_1599 got=%h exp=%h", rv_log[0], mem[1599]); end
         n_checks++;
         if (rv_log[1] !== 8'h00) begin n_fail++; $display("FAIL boundary_1600 got=%h exp=00", rv_log[1]); end
         n_checks++;
         if (rv_log[2] !== 8'h00) begin n_fail++; $display("FAIL boundary_2047 got=%h exp=00", rv_log[2]); end
      end
   endtask

   task automatic test_mid_reset();
      req = 4'b0100;
      set_addr(2, 11'd7);
      run_cycle();
      req = '0;
      #2;
      rst_n = 1'b0;
      model_reset();
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL midrst_rvalid got=%b exp=0000", rvalid); end
         n_checks++;
         if (rom_addr !== 11'd0) begin n_fail++; $display("FAIL midrst_rom_addr got=%0d exp=0", rom_addr); end
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req   = 4'b1111;
      run_cycle();
      n_checks++;
      if (obs_gnt !== 4'b0001) begin n_fail++; $display("FAIL midrst_restart got=%b exp=0001", obs_gnt); end
      drain();
   endtask

   task automatic test_random();
      logic          pend [N];
      int            waitc[N];
      logic [AW-1:0] edge_addr[4];
      edge_addr[0] = 11'd1598;
      edge_addr[1] = 11'd1599;
      edge_addr[2] = 11'd1600;
      edge_addr[3] = 11'd2047;
      apply_reset();
      for (int i = 0; i < N; i++) begin pend[i] = 1'b0; waitc[i] = 0; end
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) != 0) begin
               pend[i] = 1'b1;
               if ($urandom_range(0, 3) == 0) set_addr(i, edge_addr[$urandom_range(0, 3)]);
               else                           set_addr(i, AW'($urandom_range(0, 2047)));
            end
            req[i] = pend[i];
         end
         run_cycle();
         for (int i = 0; i < N; i++) begin
            if (i == last_win) begin
               waitc[i] = 0;
               if ($urandom_range(0, 1) == 0) pend[i] = 1'b0;
               else set_addr(i, AW'($urandom_range(0, 2047)));
            end else if (pend[i]) begin
               waitc[i]++;
               n_checks++;
               if (waitc[i] > N - 1) begin
                  n_fail++;
                  $display("FAIL fairness req=%0d waited=%0d max=%0d", i, waitc[i], N - 1);
               end
            end
         end
      end
      drain();
   endtask

   initial begin
      for (int a = 0; a < 2048; a++) mem[a] = 8'($urandom_range(1, 255));
      mem[5] = 8'hA5;
      rst_n    = 1'b0;
      req      = '0;
      req_addr = '0;
      test_reset();
      test_single();
      test_rotation();
      test_pointer();
      test_boundary();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout bench did not complete within 200000 time units");
      $fatal(1);
   end

endmodule

// File: doc/icon_rom_arbiter.md
Name: icon_rom_arbiter

Overview:
- Shares one combinational 40x40 x 8-bit icon ROM (DEPTH words, 11-bit address) between N_REQ pixel requesters, e.g. tank renderers, water-tile animator and HUD.
- Fair round-robin arbitration; one ROM access is accepted per cycle.
- Registered ROM address and registered read data; returns the data to the winning requester with a one-hot valid.
- Sits between the renderer pipelines and the icon ROM instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 11, ROM address width
- DATA_W, 8, pixel data width
- DEPTH, 1600, valid ROM words (40x40)
- OOB_DATA, 8'h00, data returned for an address >= DEPTH

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  per-requester request; held with its address until granted
- req_addr  input  N_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- gnt  output  N_REQ  one-hot combinational accept; transfer occurs on the clock edge where req[i]&gnt[i]
- rvalid  output  N_REQ  one-hot, 1-cycle pulse marking rdata for requester i
- rdata  output  DATA_W  read data, meaningful only while |rvalid
- rom_addr  output  ADDR_W  registered address driven to the ROM
- rom_data  input  DATA_W  combinational ROM output for rom_addr

Behaviour:
- Reset, asynchronous on rst_n low: ptr=0, rom_addr=0, rvalid=0, rdata=0, internal sel/oob/valid stage registers=0. gnt is 0 during reset because it is gated by rst_n.
- Arbitration is combinational within cycle t:
  - Scan req starting at index ptr, wrapping modulo N_REQ.
  - The first set bit wins and gnt is one-hot on that bit.
  - No req set: gnt=0 and ptr is unchanged.
- On the accepting edge:
  - ptr <= (winner+1) mod N_REQ
  - rom_addr <= req_addr[winner]
  - sel1 <= one-hot winner
  - oob1 <= (req_addr[winner] >= DEPTH)
  - v1 <= 1
- No accept: v1 <= 0. rom_addr holds its value.
- Stage 2, next edge:
  - rdata <= oob1 ? OOB_DATA : rom_data
  - rvalid <= v1 ? sel1 : 0
  - When v1=0, rdata holds its value.
- Latency:
  - gnt in cycle t, then rom_addr valid in t+1, then rvalid/rdata valid in t+2.
  - Throughput is 1 access per cycle, fully pipelined with no bubbles.
- Requester rules:
  - Keep req and address stable until gnt.
  - After gnt, the requester may drop req or present a new address in the next cycle; a held req is re-arbitrated.
  - Responses arrive in grant order; each requester sees them in issue order.
- Fairness: with all requesters busy, grants rotate 0,1,..,N_REQ-1,0. A requester waits at most N_REQ-1 cycles.
- Simultaneous events: only one grant per cycle; the others see gnt=0 and must hold.
- Address boundary:
  - Address DEPTH-1 (1599) reads normally.
  - Addresses 1600..2047 are granted normally and return OOB_DATA; no error is signalled.
- Reset mid-operation: in-flight accesses are discarded with no rvalid, and arbitration restarts at requester 0 after rst_n deasserts.

Decomposition:
- Shared package icon_pkg:
  - ICON_W=40, ICON_H=40, ICON_DEPTH=1600, ICON_ADDR_W=11, PIX_W=8
  - TRANSPARENT_PIX=8'h00
- Sub-module rr_arbiter, parameter N; ports clk, rst_n, req, gnt, advance.
  - Holds ptr and produces combinational one-hot gnt.
  - Reused later by the bullet/sprite schedulers.
- The top level contains the address mux, OOB compare and the two pipeline stages.

Test Plan:
- Reset check: hold rst_n=0 with req=4'b1111 -> gnt=0, rvalid=0, rdata=0, rom_addr=0. Release, then first gnt=4'b0001.
- Single requester: req[2]=1, addr=11'd5 in cycle t, ROM model mem[5]=8'hA5 -> gnt=4'b0100 at t, rom_addr=5 at t+1, rvalid=4'b0100 and rdata=8'hA5 at t+2.
- Fair rotation: all four requesters hold req for 8 cycles with distinct addresses -> gnt sequence 1,2,4,8,1,2,4,8. rvalid repeats the same sequence 2 cycles later with matching data.
- Pointer update: grant req0, then only req0 and req3 request -> next grant goes to req3 (ptr=1 scans 1,2,3), then to req0.
- Address boundary: addr 1599 -> mem[1599]. Addr 1600 and 2047 -> rdata=8'h00 with rvalid asserted.
- Mid-pipeline reset: pull rst_n low asynchronously one cycle after a grant -> no rvalid ever appears for that access. After release, ptr=0 and normal operation resumes.
